// File: rtl/cmd_receive.sv
// UART (8N1) command receiver: deserialises bytes from rx and parses
// 4-byte header/address/data/checksum frames into register-write strobes.
module cmd_receive #(
  parameter int unsigned clk_freq     = 100_000_000,
  parameter int unsigned baud_rate    = 4_000_000,
  parameter logic [7:0]  header       = 8'hA5,
  parameter int unsigned timeout_bits = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  output logic       chk_err
);

  localparam int unsigned CPB     = clk_freq / baud_rate;
  localparam int unsigned CNT_W   = $clog2(CPB);
  localparam int unsigned TO_CLKS = timeout_bits * CPB;
  localparam int unsigned TO_W    = $clog2(TO_CLKS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } bit_state_t;

  typedef enum logic [1:0] {
    P_HDR,
    P_ADDR,
    P_DATA,
    P_CHK
  } parse_state_t;

  logic             rx_m;
  logic             rx_s;
  bit_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  parse_state_t     p_state;
  logic [3:0]       addr_lat;
  logic [7:0]       data_lat;
  logic [TO_W-1:0]  tcnt;

  // Two-flop synchroniser; idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
              state    <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Priority: frame error, then a received byte, then the inter-byte timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state  <= P_HDR;
      addr_lat <= '0;
      data_lat <= '0;
      tcnt     <= '0;
      wr_en    <= 1'b0;
      chk_err  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en   <= 1'b0;
      chk_err <= 1'b0;
      if (frame_err) begin
        p_state <= P_HDR;
        tcnt    <= '0;
      end else if (rx_valid) begin
        tcnt <= '0;
        case (p_state)
          P_HDR: begin
            if (rx_byte == header) p_state <= P_ADDR;
          end
          P_ADDR: begin
            if (rx_byte[7:4] == 4'h0) begin
              addr_lat <= rx_byte[3:0];
              p_state  <= P_DATA;
            end else begin
              p_state <= P_HDR;
            end
          end
          P_DATA: begin
            data_lat <= rx_byte;
            p_state  <= P_CHK;
          end
          P_CHK: begin
            if (rx_byte == (header ^ {4'h0, addr_lat} ^ data_lat)) begin
              wr_addr <= addr_lat;
              wr_data <= data_lat;
              wr_en   <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
            p_state <= P_HDR;
          end
          default: p_state <= P_HDR;
        endcase
      end else if (p_state == P_HDR) begin
        tcnt <= '0;
      end else if (tcnt == TO_LAST) begin
        p_state <= P_HDR;
        tcnt    <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_receive.sv
// Bench for cmd_receive: directed scenarios plus randomized frames checked
// against a frame-level model of the expected register writes.
module tb_cmd_receive;

  localparam int CPB = 25;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       chk_err;

  cmd_receive #(
    .clk_freq(100_000_000),
    .baud_rate(4_000_000),
    .header(8'hA5),
    .timeout_bits(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_wr = 0, n_chk = 0, n_ferr = 0;
  int unsigned last_valid_cyc = 0;
  logic [3:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic [7:0] rxq[$];

  logic [3:0] exp_addr = '0;
  logic [7:0] exp_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_valid++;
        rxq.push_back(rx_byte);
        last_valid_cyc = cyc;
      end
      if (wr_en) begin
        n_wr++;
        last_wr_addr = wr_addr;
        last_wr_data = wr_data;
      end
      if (chk_err) n_chk++;
      if (frame_err) n_ferr++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
  endtask

  task automatic test_reset;
    logic [29:0] outs;
    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rx = 1'($urandom);
      idle(1);
    end
    outs = {rx_byte, rx_valid, wr_en, wr_addr, wr_data, frame_err, chk_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_hold outs got %0h exp 0", outs);
    end
    rx = 1'b1;
    rst_n = 1'b1;
    idle(1000);
    outs = {rx_byte, rx_valid, wr_en, wr_addr, wr_data, frame_err, chk_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_release outs got %0h exp 0", outs);
    end
    checks++;
    if (n_valid + n_wr + n_chk + n_ferr != 0) begin
      errors++;
      $display("FAIL reset_strobes got %0d exp 0", n_valid + n_wr + n_chk + n_ferr);
    end
  endtask

  task automatic test_single_byte;
    int v0, w0, lat;
    int unsigned t0;
    rxq.delete();
    v0 = n_valid; w0 = n_wr;
    t0 = cyc;
    send_byte(8'h3C, 1'b1);
    idle(10);
    checks++;
    if (n_valid - v0 != 1) begin
      errors++;
      $display("FAIL single_count got %0d exp 1", n_valid - v0);
    end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h3C) begin
      errors++;
      $display("FAIL single_byte got %0h exp 3c", (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
    lat = int'(last_valid_cyc - t0);
    checks++;
    if (lat < 239 || lat > 241) begin
      errors++;
      $display("FAIL single_latency got %0d exp 240+-1", lat);
    end
    checks++;
    if (n_wr != w0) begin
      errors++;
      $display("FAIL single_wr got %0d exp 0", n_wr - w0);
    end
  endtask

  task automatic test_valid_frame;
    int w0, c0;
    logic [7:0] fr[4];
    fr = '{8'hA5, 8'h03, 8'h7E, 8'hD8};
    rxq.delete();
    w0 = n_wr; c0 = n_chk;
    for (int i = 0; i < 4; i++) send_byte(fr[i], 1'b1);
    idle(10);
    exp_addr = 4'h3; exp_data = 8'h7E;
    checks++;
    if (n_wr - w0 != 1) begin
      errors++;
      $display("FAIL frame_wr_count got %0d exp 1", n_wr - w0);
    end
    checks++;
    if (last_wr_addr !== exp_addr || last_wr_data !== exp_data) begin
      errors++;
      $display("FAIL frame_wr_strobe got %0h/%0h exp %0h/%0h",
               last_wr_addr, last_wr_data, exp_addr, exp_data);
    end
    checks++;
    if (wr_addr !== exp_addr || wr_data !== exp_data) begin
      errors++;
      $display("FAIL frame_wr_hold got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_addr, exp_data);
    end
    checks++;
    if (n_chk != c0) begin
      errors++;
      $display("FAIL frame_chk got %0d exp 0", n_chk - c0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxq.size() != 4 || rxq[i] !== fr[i]) begin
        errors++;
        $display("FAIL frame_rx_byte%0d got %0h exp %0h", i, (rxq.size() > i) ? rxq[i] : 8'hxx, fr[i]);
      end
    end
  endtask

  task automatic test_bad_checksum;
    int w0, c0;
    logic [7:0] fr[4];
    fr = '{8'hA5, 8'h05, 8'h11, 8'h00};
    w0 = n_wr; c0 = n_chk;
    for (int i = 0; i < 4; i++) send_byte(fr[i], 1'b1);
    idle(10);
    checks++;
    if (n_chk - c0 != 1) begin
      errors++;
      $display("FAIL badchk_count got %0d exp 1", n_chk - c0);
    end
    checks++;
    if (n_wr != w0) begin
      errors++;
      $display("FAIL badchk_wr got %0d exp 0", n_wr - w0);
    end
    checks++;
    if (wr_addr !== exp_addr || wr_data !== exp_data) begin
      errors++;
      $display("FAIL badchk_hold got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_addr, exp_data);
    end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_byte(8'h55, 1'b0);
    idle(10);
    checks++;
    if (n_ferr - f0 != 1 || n_valid != v0) begin
      errors++;
      $display("FAIL ferr_pulse got ferr=%0d valid=%0d exp 1/0", n_ferr - f0, n_valid - v0);
    end
    idle(500);
    rx = 1'b1;
    idle(300);
    checks++;
    if (n_ferr - f0 != 1 || n_valid != v0) begin
      errors++;
      $display("FAIL ferr_break got ferr=%0d valid=%0d exp 1/0", n_ferr - f0, n_valid - v0);
    end
    rxq.delete();
    send_byte(8'h81, 1'b1);
    idle(10);
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h81) begin
      errors++;
      $display("FAIL ferr_recover got %0h exp 81", (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = n_valid + n_wr + n_chk + n_ferr;
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(400);
    checks++;
    if (n_valid + n_wr + n_chk + n_ferr != s0) begin
      errors++;
      $display("FAIL glitch_strobes got %0d exp 0", n_valid + n_wr + n_chk + n_ferr - s0);
    end
  endtask

  task automatic test_timeout;
    int w0, c0, v0;
    w0 = n_wr; c0 = n_chk; v0 = n_valid;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(801);
    send_byte(8'h7E, 1'b1);
    send_byte(8'hD8, 1'b1);
    idle(10);
    checks++;
    if (n_wr != w0 || n_chk != c0) begin
      errors++;
      $display("FAIL timeout_strobes got wr=%0d chk=%0d exp 0/0", n_wr - w0, n_chk - c0);
    end
    checks++;
    if (n_valid - v0 != 4) begin
      errors++;
      $display("FAIL timeout_bytes got %0d exp 4", n_valid - v0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int s0;
    logic [29:0] outs;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    rx = 1'b0;
    idle(100);
    rst_n = 1'b0;
    idle(5);
    rst_n = 1'b1;
    rx = 1'b1;
    s0 = n_valid + n_wr + n_chk + n_ferr;
    idle(400);
    exp_addr = '0; exp_data = '0;
    outs = {rx_byte, rx_valid, wr_en, wr_addr, wr_data, frame_err, chk_err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midreset_outs got %0h exp 0", outs);
    end
    checks++;
    if (n_valid + n_wr + n_chk + n_ferr != s0) begin
      errors++;
      $display("FAIL midreset_strobes got %0d exp 0", n_valid + n_wr + n_chk + n_ferr - s0);
    end
  endtask

  task automatic test_random_frames;
    int kind, w0, c0;
    logic [7:0] fr[4];
    logic [7:0] a, d, c;
    for (int f = 0; f < 8; f++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) a = {4'($urandom_range(1, 15)), 4'($urandom)};
      else a = {4'h0, 4'($urandom)};
      d = 8'($urandom);
      if (kind == 2 && d == HDR) d = 8'h00;
      c = HDR ^ a ^ d;
      if (kind == 1) c = c ^ 8'($urandom_range(1, 255));
      if (kind == 2 && c == HDR) c = 8'h00;
      fr = '{HDR, a, d, c};
      rxq.delete();
      w0 = n_wr; c0 = n_chk;
      for (int i = 0; i < 4; i++) send_byte(fr[i], 1'b1);
      idle(10);
      if (kind == 0) begin
        exp_addr = a[3:0];
        exp_data = d;
      end
      checks++;
      if (n_wr - w0 != ((kind == 0) ? 1 : 0) || n_chk - c0 != ((kind == 1) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand%0d_kind%0d strobes got wr=%0d chk=%0d", f, kind, n_wr - w0, n_chk - c0);
      end
      checks++;
      if (wr_addr !== exp_addr || wr_data !== exp_data) begin
        errors++;
        $display("FAIL rand%0d_regs got %0h/%0h exp %0h/%0h", f, wr_addr, wr_data, exp_addr, exp_data);
      end
      checks++;
      if (rxq.size() != 4 || rxq[0] !== fr[0] || rxq[1] !== fr[1] || rxq[2] !== fr[2] || rxq[3] !== fr[3]) begin
        errors++;
        $display("FAIL rand%0d_bytes got n=%0d exp %0h %0h %0h %0h", f, rxq.size(), fr[0], fr[1], fr[2], fr[3]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_valid_frame;
    test_bad_checksum;
    test_frame_error;
    test_glitch;
    test_timeout;
    test_reset_mid_frame;
    test_random_frames;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_receive.md
# cmd_receive

Host-to-FPGA command path for the coincidence counter. Deserialises 8N1 UART bytes from the `rx` pin and parses 4-byte write frames. Each valid frame produces one register-write strobe. Downstream configuration registers (batch size, channel enables, delay taps) consume the strobe. It uses the same clock and baud plan as the transmit side.

## Interface
Parameters:
- `clk_freq`, 100_000_000: system clock frequency in Hz.
- `baud_rate`, 4_000_000: bit rate. CPB = clk_freq/baud_rate (truncated); CPB ≥ 8 is required.
- `header`, 8'hA5: frame start byte.
- `timeout_bits`, 32: inter-byte timeout, in bit-times.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx` in 1: UART line, asynchronous, idle high.
- `rx_byte` out 8: last correctly framed byte.
- `rx_valid` out 1: one-cycle strobe; `rx_byte` is new.
- `wr_en` out 1: one-cycle register-write strobe.
- `wr_addr` out 4: write address; held until the next write.
- `wr_data` out 8: write data; held until the next write.
- `frame_err` out 1: one-cycle strobe on a bad stop bit.
- `chk_err` out 1: one-cycle strobe on a checksum mismatch.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1, giving `rx_s`.
- **Bit FSM states:** IDLE, START, DATA, STOP, BREAK. A counter `cnt` counts clocks; a counter `bit_idx` spans 0..7.
- **IDLE:** when `rx_s`==0, go to START with cnt←0.
- **START:** at cnt==CPB/2−1, sample `rx_s`.
  - Sample 0: go to DATA with cnt←0, bit_idx←0.
  - Sample 1: glitch; return to IDLE with no output.
- **DATA:** at cnt==CPB−1, shift `rx_s` into the shift register LSB-first and set cnt←0. After bit_idx==7 go to STOP.
- **STOP:** at cnt==CPB−1, sample `rx_s`.
  - Sample 1: load `rx_byte`, pulse `rx_valid`, go to IDLE. Back-to-back bytes with no idle gap are therefore accepted.
  - Sample 0: pulse `frame_err`, discard the byte, go to BREAK.
- **BREAK:** wait for `rx_s`==1, then go to IDLE.
- **Frame parser states:** P_HDR, P_ADDR, P_DATA, P_CHK. The parser advances only on `rx_valid`.
- **P_HDR:** a byte equal to `header` advances to P_ADDR. Any other byte is ignored.
- **P_ADDR:** bits [7:4] must be 0; otherwise return to P_HDR silently. Otherwise latch address [3:0] and advance.
- **P_DATA:** latch the data byte and advance.
- **P_CHK:** compare the byte with header ^ addr_byte ^ data_byte.
  - Equal: update `wr_addr`/`wr_data` and pulse `wr_en`.
  - Not equal: pulse `chk_err`; `wr_addr`/`wr_data` are unchanged.
  - Either way, return to P_HDR.
- **Parser reset conditions** (any of these sends the parser to P_HDR):
  - `frame_err` in any parser state.
  - Timeout: parser is not in P_HDR and no `rx_valid` has occurred for timeout_bits×CPB clocks. The timeout counter clears on every `rx_valid`. It must not overflow: it saturates or stops once the parser is in P_HDR.
- **Simultaneous events:** the timeout expiring in the same cycle as `rx_valid` → `rx_valid` wins and the byte is processed.

## Timing
- **Reset values:** all outputs 0; bit FSM in IDLE; parser in P_HDR; all counters 0.
- **Reset mid-byte or mid-frame:** everything is abandoned. No strobe is emitted during or after reset.
- **Sample points,** in clocks after entering START:
  - start bit: CPB/2
  - data bit k: CPB/2 + (k+1)·CPB
  - stop bit: CPB/2 + 9·CPB
- **`rx_valid` / `frame_err`:** registered; they assert the cycle after the stop sample. From the falling edge on the pin, latency is 3 + CPB/2 + 9·CPB clocks, ±1 (synchroniser phase).
- **`wr_en` / `chk_err`:** assert exactly 1 cycle after the `rx_valid` of the checksum byte.
- **`wr_addr` / `wr_data`:** valid in the same cycle as `wr_en`.
- **Strobe width:** all strobes are exactly 1 cycle wide and never overlap for the same byte.

## Test plan
Use CPB=25 (clk_freq=100e6, baud_rate=4e6) throughout.
- **Reset:** hold `rst_n`=0 with `rx` toggling, then release with `rx`=1 for 1000 clocks → all outputs stay 0.
- **Single byte:** send 0x3C → one `rx_valid` with `rx_byte`=0x3C, at 240±1 clocks after the falling edge on the pin; `wr_en` stays 0.
- **Valid frame:** send frame A5,03,7E,D8 back-to-back → one `wr_en` with `wr_addr`=3, `wr_data`=0x7E; no `chk_err`.
- **Bad checksum:** send A5,05,11,00 after the previous test → one `chk_err`, no `wr_en`, `wr_addr`/`wr_data` still 3/0x7E.
- **Framing error:**
  - Send byte 0x55 with its stop bit at 0 → `frame_err` pulses, no `rx_valid`.
  - Then hold `rx` low for 500 clocks and release → no further strobes.
  - Then send 0x81 → `rx_valid` with `rx_byte`=0x81.
- **Glitch:** drive a 10-clock low pulse on `rx` → no outputs.
- **Timeout:** send A5,03, idle 801 clocks, then send 7E,D8 → no `wr_en`, no `chk_err` (the parser treats 7E and D8 as non-header bytes).
